// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone master arbiter.
// State encoding, index width and pointer wrap helper.
package wb_arb_pkg;

    localparam int MAX_M = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] wrap_inc(
        input logic [IDX_W-1:0] i,
        input int               n
    );
        return (int'(i) >= n - 1) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_pick.sv
// Circular priority encoder: first request at or after ptr.
// Combinational; ptr is assumed to be below N.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N) k = k - N;
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone master arbiter with bus watchdog.
// Grant is held for a whole cyc; stalled strobes abort with err.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 3,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_M-1:0]       m_cyc_i,
    input  logic [NUM_M-1:0]       m_stb_i,
    input  logic [NUM_M-1:0]       m_we_i,
    input  logic [NUM_M*ADR_W-1:0] m_adr_i,
    input  logic [NUM_M*DAT_W-1:0] m_dat_i,
    input  logic [NUM_M*4-1:0]     m_sel_i,
    output logic [DAT_W-1:0]       m_dat_o,
    output logic [NUM_M-1:0]       m_ack_o,
    output logic [NUM_M-1:0]       m_err_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [3:0]         s_sel_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    output logic [NUM_M-1:0]   grant_o,
    output logic               tmo_irq_o,
    output logic [2:0]         tmo_mst_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q;
    logic [NUM_M-1:0] grant_q;
    logic [NUM_M-1:0] err_q;
    logic [IDX_W-1:0] gidx_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] tmo_mst_q;
    logic             irq_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NUM_M-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             busy;
    logic             stall;
    logic             expire;

    rr_pick #(.N(NUM_M)) u_pick (
        .req_i   (m_cyc_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    assign busy = (state_q == BUSY);

    // One-hot AND-OR mux keeps the slave side at zero outside BUSY.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (busy) begin
            s_cyc_o = |(m_cyc_i & grant_q);
            s_stb_o = |(m_stb_i & grant_q);
            s_we_o  = |(m_we_i & grant_q);
            for (int k = 0; k < NUM_M; k++) begin
                if (grant_q[k]) begin
                    s_adr_o = s_adr_o | m_adr_i[k*ADR_W +: ADR_W];
                    s_dat_o = s_dat_o | m_dat_i[k*DAT_W +: DAT_W];
                    s_sel_o = s_sel_o | m_sel_i[k*4 +: 4];
                end
            end
        end
    end

    assign stall  = busy && s_stb_o && !s_ack_i;
    assign expire = (TIMEOUT != 0) && stall
                    && (cnt_q == CNT_W'(TIMEOUT - 1));

    assign m_ack_o   = busy ? (grant_q & {NUM_M{s_ack_i}}) : '0;
    assign m_dat_o   = s_dat_i;
    assign m_err_o   = err_q;
    assign grant_o   = grant_q;
    assign tmo_irq_o = irq_q;
    assign tmo_mst_o = tmo_mst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            err_q     <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            tmo_mst_q <= '0;
            irq_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            err_q <= '0;
            irq_q <= 1'b0;
            if (stall && TIMEOUT != 0) cnt_q <= cnt_q + 1'b1;
            else                       cnt_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= BUSY;
                        grant_q <= pick_gnt;
                        gidx_q  <= pick_idx;
                    end
                end
                BUSY: begin
                    if (expire) begin
                        state_q   <= ABORT;
                        err_q     <= grant_q;
                        irq_q     <= 1'b1;
                        tmo_mst_q <= gidx_q;
                    end else if (!s_cyc_o) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        ptr_q   <= wrap_inc(gidx_q, NUM_M);
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    ptr_q   <= wrap_inc(gidx_q, NUM_M);
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter with a grant/data scoreboard.
// Second instance runs with the watchdog disabled.
module tb_wb_master_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  m_cyc_i = '0;
    logic [N-1:0]  m_stb_i = '0;
    logic [N-1:0]  m_we_i  = '0;
    logic [N*32-1:0] m_adr_i = '0;
    logic [N*32-1:0] m_dat_i = '0;
    logic [N*4-1:0]  m_sel_i = '0;
    logic [31:0]   s_dat_i = '0;
    logic          s_ack_i = 1'b0;

    logic [31:0]   m_dat_o, s_adr_o, s_dat_o;
    logic [N-1:0]  m_ack_o, m_err_o, grant_o;
    logic          s_cyc_o, s_stb_o, s_we_o, tmo_irq_o;
    logic [3:0]    s_sel_o;
    logic [2:0]    tmo_mst_o;

    logic [31:0]   z_dat_o, z_adr_o, z_sdat_o;
    logic [N-1:0]  z_ack_o, z_err_o, z_grant_o;
    logic          z_cyc_o, z_stb_o, z_we_o, z_irq_o;
    logic [3:0]    z_sel_o;
    logic [2:0]    z_mst_o;

    int total  = 0;
    int passes = 0;
    int exp_g[$];
    logic [31:0] exp_d[$];

    always #5 clk = ~clk;

    wb_master_arbiter #(.NUM_M(N), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .tmo_irq_o(tmo_irq_o), .tmo_mst_o(tmo_mst_o)
    );

    wb_master_arbiter #(.NUM_M(N), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(z_dat_o), .m_ack_o(z_ack_o), .m_err_o(z_err_o),
        .s_cyc_o(z_cyc_o), .s_stb_o(z_stb_o), .s_we_o(z_we_o),
        .s_adr_o(z_adr_o), .s_dat_o(z_sdat_o), .s_sel_o(z_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(z_grant_o), .tmo_irq_o(z_irq_o), .tmo_mst_o(z_mst_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        s_ack_i = 1'b0;
        #1 rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic request(input int m);
        m_cyc_i[m] = 1'b1;
        m_adr_i[m*32 +: 32] = 32'h1000 + 32'(m * 16);
        m_sel_i[m*4 +: 4] = 4'hf;
    endtask

    task automatic wait_grant(output int g);
        int n;
        n = 0;
        while (grant_o == '0 && n < 20) begin
            cyc();
            n++;
        end
        check("grant_latency", 32'(n), 32'd1);
        g = (exp_g.size() != 0) ? exp_g.pop_front() : 0;
        check("grant_onehot", 32'(grant_o), 32'(1 << g));
    endtask

    task automatic do_access(input int m, input int stalls,
                             input logic [31:0] rdat);
        m_stb_i[m] = 1'b1;
        repeat (stalls) cyc();
        #1;
        check("s_adr", s_adr_o, 32'h1000 + 32'(m * 16));
        s_ack_i = 1'b1;
        s_dat_i = rdat;
        exp_d.push_back(rdat);
        #1;
        check("m_ack", 32'(m_ack_o), 32'(1 << m));
        check("m_dat", m_dat_o, exp_d.pop_front());
        cyc();
        s_ack_i = 1'b0;
        m_stb_i[m] = 1'b0;
    endtask

    task automatic release_m(input int m);
        m_cyc_i[m] = 1'b0;
        cyc();
        check("idle_after_release", 32'(grant_o), 32'd0);
    endtask

    int g;
    int bad;

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_irq", 32'(tmo_irq_o), 32'd0);
        check("rst_mst", 32'(tmo_mst_o), 32'd0);
        check("rst_err_ack", 32'({m_err_o, m_ack_o}), 32'd0);
        do_reset();

        request(1);
        exp_g.push_back(1);
        wait_grant(g);
        check("s_cyc_granted", 32'(s_cyc_o), 32'd1);
        do_access(g, 3, 32'hdead_0001);
        release_m(g);

        do_reset();
        request(0);
        request(1);
        request(2);
        exp_g.push_back(0);
        exp_g.push_back(1);
        exp_g.push_back(2);
        for (int i = 0; i < 3; i++) begin
            wait_grant(g);
            do_access(g, 1, 32'h1111_0000 + 32'(i));
            release_m(g);
        end
        request(0);
        request(2);
        exp_g.push_back(0);
        exp_g.push_back(2);
        for (int i = 0; i < 2; i++) begin
            wait_grant(g);
            do_access(g, 0, 32'h2222_0000 + 32'(i));
            release_m(g);
        end

        do_reset();
        request(1);
        exp_g.push_back(1);
        wait_grant(g);
        request(0);
        exp_g.push_back(0);
        for (int i = 0; i < 4; i++) begin
            do_access(1, 0, 32'h3333_0000 + 32'(i));
            check("hold_grant", 32'(grant_o), 32'b010);
        end
        release_m(1);
        wait_grant(g);
        release_m(g);

        do_reset();
        request(2);
        exp_g.push_back(2);
        wait_grant(g);
        m_stb_i[2] = 1'b1;
        repeat (15) cyc();
        check("pre_tmo_err", 32'({tmo_irq_o, m_err_o}), 32'd0);
        check("pre_tmo_cyc", 32'(s_cyc_o), 32'd1);
        cyc();
        check("tmo_err", 32'(m_err_o), 32'b100);
        check("tmo_irq", 32'(tmo_irq_o), 32'd1);
        check("tmo_mst", 32'(tmo_mst_o), 32'd2);
        check("tmo_cyc", 32'(s_cyc_o), 32'd0);
        m_cyc_i[2] = 1'b0;
        m_stb_i[2] = 1'b0;
        cyc();
        check("tmo_pulse", 32'({tmo_irq_o, m_err_o}), 32'd0);
        check("tmo_sticky", 32'(tmo_mst_o), 32'd2);

        do_reset();
        request(2);
        exp_g.push_back(2);
        wait_grant(g);
        do_access(2, 15, 32'h4444_0016);
        check("late_ack_noerr", 32'({tmo_irq_o, m_err_o}), 32'd0);
        check("late_ack_grant", 32'(grant_o), 32'b100);
        release_m(2);

        do_reset();
        request(0);
        m_stb_i[0] = 1'b1;
        cyc();
        check("wd_off_grant", 32'(z_grant_o), 32'b001);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (z_irq_o || z_err_o != '0 || !z_cyc_o) bad++;
        end
        check("wd_off_no_abort", 32'(bad), 32'd0);
        m_stb_i[0] = 1'b0;
        m_cyc_i[0] = 1'b0;

        do_reset();
        request(1);
        exp_g.push_back(1);
        wait_grant(g);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_mid_grant", 32'(grant_o), 32'd0);
        check("rst_mid_ack", 32'({m_err_o, m_ack_o}), 32'd0);
        m_cyc_i[1] = 1'b0;
        cyc();
        rst = 1'b1;
        request(2);
        request(0);
        exp_g.push_back(0);
        wait_grant(g);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
